// File: rtl/bin2bcd_disp.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) that
// produces the packed digit word for the 8-digit scanned display driver.

module bin2bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    // Carry out of the nibble is dropped; it cannot occur for in-range values.
    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
endmodule

module bin2bcd_disp #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [BIN_W-1:0]      Bin_in,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow,
    output logic [4*DIGITS-1:0]   Disp_data
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]      MAX_DEC = pow10(DIGITS) - 64'd1;
    localparam logic [BCD_W-1:0] ALL_9   = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               in_ovf;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bin2bcd_add3 u_add3 (
                .nib_i (bcd_q[4*g +: 4]),
                .nib_o (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    assign in_ovf = {{(64-BIN_W){1'b0}}, Bin_in} > MAX_DEC;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    bin_d      = Bin_in;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = in_ovf;
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Adjust-then-shift in a single cycle: one binary bit per clock.
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                disp_d  = ovf_pend_q ? ALL_9 : bcd_q;
                ovf_d   = ovf_pend_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Overflow  = ovf_q;
    assign Disp_data = disp_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Randomised bench for bin2bcd_disp: a cycle-timed behavioural model is compared
// every cycle, plus directed scenarios with literal expectations.

module tb_bin2bcd_disp;
    localparam int BIN_W = 27;
    localparam int DIGITS = 8;
    localparam longint MAXV = 64'd99_999_999;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [26:0] Bin_in = '0;
    logic        Busy, Done, Overflow;
    logic [31:0] Disp_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bin2bcd_disp #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bin_in(Bin_in),
        .Busy(Busy), .Done(Done), .Overflow(Overflow), .Disp_data(Disp_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] bcd_of(input longint v);
        logic [31:0] r;
        longint x;
        if (v > MAXV) return 32'h9999_9999;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a conversion accepted at edge t0 completes at t0+BIN_W+1,
    // Busy covers edges t0..t0+BIN_W-1, the next accept is possible only after Done.
    longint      t = 0, m_t0 = 0, m_val = 0;
    bit          m_active = 1'b0;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_ovf = 1'b0;
    logic [31:0] exp_disp = '0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_active = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_ovf  = 1'b0;
            exp_disp = '0;
        end else begin
            t++;
            exp_done = 1'b0;
            if (m_active && t == m_t0 + BIN_W + 1) begin
                exp_disp = bcd_of(m_val);
                exp_ovf  = (m_val > MAXV);
                exp_done = 1'b1;
                m_active = 1'b0;
            end else if (!m_active && Start) begin
                m_active = 1'b1;
                m_t0     = t;
                m_val    = longint'(Bin_in);
            end
            exp_busy = m_active && (t - m_t0) < BIN_W;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy", 64'(Busy), 64'(exp_busy));
            check("done", 64'(Done), 64'(exp_done));
            check("overflow", 64'(Overflow), 64'(exp_ovf));
            check("disp_data", 64'(Disp_data), 64'(exp_disp));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One-cycle Start pulse; returns edges from accept to Done (-1 on timeout).
    task automatic conv(input logic [26:0] v, output int lat);
        Bin_in = v;
        Start  = 1'b1;
        tick(1);
        Start = 1'b0;
        lat = 0;
        while (!Done && lat < 40) begin
            tick(1);
            lat++;
        end
        if (!Done) lat = -1;
    endtask

    initial begin
        int lat, bc, dn, ndone, nxt;
        bit prev_busy, stable;
        logic [31:0] dval[3];
        int dcyc[3];
        logic [31:0] dv;

        #2 Reset = 1'b1;
        chk_en = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(1);
        check("reset_disp", 64'(Disp_data), 64'h0);
        check("reset_busy", 64'(Busy), 64'h0);
        check("reset_ovf", 64'(Overflow), 64'h0);

        check("model_pin_a", 64'(bcd_of(12_345_678)), 64'h1234_5678);
        check("model_pin_b", 64'(bcd_of(100_000_000)), 64'h9999_9999);
        check("model_pin_c", 64'(bcd_of(65_535)), 64'h0006_5535);

        conv(27'd0, lat);
        check("zero_lat", 64'(lat), 64'd28);
        check("zero_disp", 64'(Disp_data), 64'h0);

        // Busy width, Done latency and Disp_data stability during the run.
        Bin_in = 27'd12_345_678;
        Start  = 1'b1;
        tick(1);
        Start = 1'b0;
        bc = 0; lat = 0; stable = 1'b1;
        while (!Done && lat < 40) begin
            if (Busy) bc++;
            if (Disp_data !== 32'h0) stable = 1'b0;
            tick(1);
            lat++;
        end
        check("main_busy_cycles", 64'(bc), 64'd27);
        check("main_lat", 64'(lat), 64'd28);
        check("main_stable", 64'(stable), 64'd1);
        check("main_disp", 64'(Disp_data), 64'h1234_5678);

        conv(27'd99_999_999, lat);
        check("max_disp", 64'(Disp_data), 64'h9999_9999);
        check("max_ovf", 64'(Overflow), 64'h0);
        conv(27'd100_000_000, lat);
        check("ovf_disp", 64'(Disp_data), 64'h9999_9999);
        check("ovf_flag", 64'(Overflow), 64'h1);
        conv(27'd5, lat);
        check("five_disp", 64'(Disp_data), 64'h0000_0005);
        check("five_ovf", 64'(Overflow), 64'h0);
        tick(2);

        // Start while busy must be ignored.
        Bin_in = 27'd4096;
        Start  = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(9);
        Bin_in = 27'd7;
        Start  = 1'b1;
        tick(1);
        Start = 1'b0;
        dn = 0; dv = '0;
        for (int i = 0; i < 40; i++) begin
            if (Done) begin dn++; dv = Disp_data; end
            tick(1);
        end
        check("ignore_done_count", 64'(dn), 64'd1);
        check("ignore_disp", 64'(dv), 64'h0000_4096);

        // Reset mid-conversion abandons it.
        Bin_in = 27'd65_535;
        Start  = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(14);
        Reset = 1'b1;
        tick(1);
        check("rst_mid_disp", 64'(Disp_data), 64'h0);
        check("rst_mid_busy", 64'(Busy), 64'h0);
        Reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 35; i++) begin
            if (Done) dn++;
            tick(1);
        end
        check("rst_mid_no_done", 64'(dn), 64'd0);
        conv(27'd65_535, lat);
        check("after_rst_disp", 64'(Disp_data), 64'h0006_5535);
        tick(2);

        // Back-to-back conversions with Start held high.
        Bin_in = 27'd1;
        Start  = 1'b1;
        nxt = 2; ndone = 0; prev_busy = Busy;
        for (int c = 0; c < 120; c++) begin
            tick(1);
            if (Busy && !prev_busy && nxt <= 3) begin
                Bin_in = 27'(nxt);
                nxt++;
            end
            prev_busy = Busy;
            if (Done && ndone < 3) begin
                dcyc[ndone] = c;
                dval[ndone] = Disp_data;
                ndone++;
            end
        end
        Start = 1'b0;
        tick(35);
        check("b2b_count", 64'(ndone), 64'd3);
        if (ndone == 3) begin
            check("b2b_gap1", 64'(dcyc[1] - dcyc[0]), 64'd29);
            check("b2b_gap2", 64'(dcyc[2] - dcyc[1]), 64'd29);
            check("b2b_v1", 64'(dval[0]), 64'h1);
            check("b2b_v2", 64'(dval[1]), 64'h2);
            check("b2b_v3", 64'(dval[2]), 64'h3);
        end

        // Random conversions with input noise and occasional resets; model checks.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: Bin_in = 27'($urandom_range(0, 999));
                1: Bin_in = 27'($urandom_range(99_999_990, 100_000_010));
                default: Bin_in = 27'($urandom());
            endcase
            Start = 1'b1;
            tick(1);
            Start = 1'b0;
            for (int i = 0; i < 30; i++) begin
                Start  = ($urandom_range(0, 3) == 0);
                Bin_in = 27'($urandom());
                if (k % 13 == 7 && i == 12) Reset = 1'b1;
                tick(1);
                Reset = 1'b0;
            end
            Start = 1'b0;
            tick(32);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
